seq_div_16: RTL and testbench

Multi-cycle unsigned 16-bit divider for the CPU datapath, using the restoring shift/subtract algorithm. It produces one quotient bit per clock. It sits beside the combinational ALU slices and is the inverse operation to the ALU's multiply path. The controller hands it operands with a start pulse and collects the quotient and remainder on a done pulse.

---
 rtl/seq_div_16.sv | 94 +++++++++
 tb/tb_seq_div_16.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seq_div_16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero completes in a single cycle with quotient all-ones and remainder = dividend.
module seq_div_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_acc, quo_acc, dsr;
    logic [WIDTH-1:0] shifted, rem_nxt, quo_nxt;
    logic [WIDTH:0]   trial;
    logic             accept, last;

    // DONE accepts a new request just like IDLE, giving back-to-back operation
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    // The partial remainder only has its MSB set after the final iteration, so the
    // bit dropped by the shift is always zero while it matters.
    always_comb begin
        shifted = {rem_acc[WIDTH-2:0], quo_acc[WIDTH-1]};
        trial   = {1'b0, shifted} - {1'b0, dsr};
        rem_nxt = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
        quo_nxt = {quo_acc[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = (divisor == '0) ? DONE : RUN;
                else       state_nxt = IDLE;
            end
            RUN:     if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            dsr         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor != '0) begin
                cnt     <= '0;
                rem_acc <= '0;
                quo_acc <= dividend;
                dsr     <= divisor;
            end else begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            rem_acc <= rem_nxt;
            quo_acc <= quo_nxt;
            cnt     <= cnt + CW'(1);
            if (last) begin
                quotient    <= quo_nxt;
                remainder   <= rem_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_div_16.sv
// Self-checking bench for seq_div_16: directed scenarios plus random operands
// compared against plain '/' and '%' arithmetic.
module tb_seq_div_16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    int n_cmp = 0;
    int n_err = 0;

    seq_div_16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue a request at the next negedge; return with the DUT in its done cycle
    // (sampled 1 time unit after the edge). poke_cyc >= 0 injects a stray start.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int poke_cyc,
                         output int lat, output int bsy);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        lat = 0; bsy = 0;
        while (!done && lat < 40) begin
            if (busy) bsy++;
            if (lat == poke_cyc) begin start = 1'b1; dividend = 16'd7; divisor = 16'd2; end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
    endtask

    // Reference: plain arithmetic, with the all-ones / dividend convention for b == 0
    task automatic check_res(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input int lat, input int bsy);
        logic [15:0] eq, er;
        eq = (b == 0) ? 16'hFFFF : a / b;
        er = (b == 0) ? a : a % b;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " latency"}, lat, (b == 0) ? 0 : 16);
        chk({tag, " busy cycles"}, bsy, (b == 0) ? 0 : 16);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(b == 0));
    endtask

    task automatic idle_step(input string tag);
        @(posedge clk); #1;
        chk({tag, " done single pulse"}, 32'(done), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat, bsy, pulses;
        logic [15:0] a, b, held_q;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset outputs", {quotient, remainder}, 32'd0);
        chk("reset dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin @(posedge clk); #1; if (done) pulses++; end
        chk("idle no done", pulses, 0);

        // Basic divides
        do_op(16'h0064, 16'h0007, -1, lat, bsy); check_res("100/7", 16'h0064, 16'h0007, lat, bsy);
        chk("100/7 literal q", quotient, 16'h000E);
        idle_step("100/7");
        do_op(16'hFFFF, 16'h0001, -1, lat, bsy); check_res("FFFF/1", 16'hFFFF, 16'h0001, lat, bsy);
        idle_step("FFFF/1");
        do_op(16'd3, 16'd10, -1, lat, bsy); check_res("3/10", 16'd3, 16'd10, lat, bsy);
        idle_step("3/10");

        // Divide by zero, then normal op clears the flag
        do_op(16'd5, 16'd0, -1, lat, bsy); check_res("5/0", 16'd5, 16'd0, lat, bsy);
        idle_step("5/0");
        do_op(16'd9, 16'd3, -1, lat, bsy); check_res("9/3", 16'd9, 16'd3, lat, bsy);
        idle_step("9/3");

        // Start during RUN is ignored
        do_op(16'd1000, 16'd10, 4, lat, bsy); check_res("ignore", 16'd1000, 16'd10, lat, bsy);
        idle_step("ignore");

        // Back-to-back: second start issued during the first op's done cycle
        do_op(16'd50, 16'd6, -1, lat, bsy); check_res("b2b first", 16'd50, 16'd6, lat, bsy);
        do_op(16'h1234, 16'h0010, -1, lat, bsy); check_res("b2b second", 16'h1234, 16'h0010, lat, bsy);
        chk("b2b literal rem", remainder, 16'h0004);
        idle_step("b2b");

        // Reset mid-operation; outputs hold the previous result until then
        held_q = quotient;
        @(negedge clk); start = 1'b1; dividend = 16'hABCD; divisor = 16'h0003;
        @(posedge clk); #1; start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        chk("run holds quotient", quotient, held_q);
        chk("run busy", 32'(busy), 32'd1);
        rst_n = 1'b0; #1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset outputs", {quotient, remainder}, 32'd0);
        pulses = 0;
        repeat (3) begin @(posedge clk); #1; if (done) pulses++; end
        chk("midreset no done", pulses, 0);
        @(negedge clk); rst_n = 1'b1;
        do_op(16'hABCD, 16'h0003, -1, lat, bsy); check_res("post reset", 16'hABCD, 16'h0003, lat, bsy);
        chk("post reset literal q", quotient, 16'h3944);
        idle_step("post reset");

        // Random operands across small, full-range and zero divisors
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            case (i % 4)
                0:       b = 16'($urandom_range(1, 15));
                1:       b = 16'($urandom);
                2:       b = 16'($urandom_range(16'h8000, 16'hFFFF));
                default: b = (i % 8 == 3) ? 16'd0 : 16'($urandom_range(1, 16'h00FF));
            endcase
            do_op(a, b, -1, lat, bsy);
            check_res($sformatf("rand%0d %0h/%0h", i, a, b), a, b, lat, bsy);
            if (i % 3 == 0) idle_step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
